// File: rtl/dmrs_chest.sv
// dmrs_chest: least-squares DMRS channel estimate H = rx * conj(ref) in saturated Q16.16.
// Optional macro DMRS_SMOOTH_EN adds a 2-tap mean output stage (latency 3 instead of 2).
module dmrs_chest #(
  parameter int NSC_MAX = 12,
  parameter int FRAC    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chest_en,
  input  logic [3:0]         Nsc,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] rx_re,
  input  logic signed [31:0] rx_im,
  input  logic signed [31:0] ref_re,
  input  logic signed [31:0] ref_im,
  output logic               h_valid,
  output logic [31:0]        h_re,
  output logic [31:0]        h_im,
  output logic [3:0]         h_idx,
  output logic               busy,
  output logic               chest_done,
  output logic               nsc_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] nsc_q, acc_q, emit_q, h_idx_q;
  logic s1_v_q, h_valid_q, nsc_err_q, accept, legal, start, pipe_busy;
  logic signed [63:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;
  logic signed [64:0] sum_re, sum_im;
  logic [31:0] raw_re, raw_im, h_re_q, h_im_q;

  function automatic logic [31:0] sat32(input logic signed [64:0] x);
    return x > 65'sh0_7FFF_FFFF ? 32'h7FFF_FFFF : x < -65'sh0_8000_0000 ? 32'h8000_0000 : x[31:0];
  endfunction

  assign legal      = (Nsc == 4'd1 || Nsc == 4'd3 || Nsc == 4'd6 || Nsc == 4'd12) && 32'(Nsc) <= NSC_MAX;
  assign start      = state_q == IDLE && chest_en && legal;
  assign in_ready   = state_q == RUN;
  assign accept     = in_valid && in_ready;
  assign busy       = state_q == RUN || state_q == DRAIN;
  assign chest_done = state_q == DONE;
  assign nsc_err    = nsc_err_q;
  assign h_valid    = h_valid_q;
  assign h_re       = h_re_q;
  assign h_im       = h_im_q;
  assign h_idx      = h_idx_q;
  // Sums are kept at 65 bits so the shift sees the exact value before clamping.
  assign sum_re = 65'(p_rr_q) + 65'(p_ii_q);
  assign sum_im = 65'(p_ir_q) - 65'(p_ri_q);
  assign raw_re = sat32(sum_re >>> FRAC);
  assign raw_im = sat32(sum_im >>> FRAC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = accept && acc_q == nsc_q - 4'd1 ? DRAIN : RUN;
      DRAIN:   state_d = pipe_busy ? DRAIN : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      nsc_q     <= '0;
      acc_q     <= '0;
      nsc_err_q <= 1'b0;
      s1_v_q    <= 1'b0;
      p_rr_q    <= '0;
      p_ii_q    <= '0;
      p_ir_q    <= '0;
      p_ri_q    <= '0;
    end else begin
      state_q   <= state_d;
      nsc_err_q <= state_q == IDLE && chest_en && !legal;
      s1_v_q    <= accept;
      if (start) begin
        nsc_q <= Nsc;
        acc_q <= '0;
      end else if (accept) acc_q <= acc_q + 4'd1;
      if (accept) begin
        p_rr_q <= 64'(rx_re) * 64'(ref_re);
        p_ii_q <= 64'(rx_im) * 64'(ref_im);
        p_ir_q <= 64'(rx_im) * 64'(ref_re);
        p_ri_q <= 64'(rx_re) * 64'(ref_im);
      end
    end

`ifdef DMRS_SMOOTH_EN
  logic s2_v_q;
  logic [31:0] r_re_q, r_im_q, p_re_q, p_im_q;
  assign pipe_busy = s1_v_q || s2_v_q;
  // Mean of two 32-bit values always fits in 32 bits, so no clamp is needed after the shift.
  function automatic logic [31:0] avg(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] s;
    s = 33'($signed(a)) + 33'($signed(b));
    return s[32:1];
  endfunction
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s2_v_q    <= 1'b0;
      r_re_q    <= '0;
      r_im_q    <= '0;
      p_re_q    <= '0;
      p_im_q    <= '0;
      h_valid_q <= 1'b0;
      h_re_q    <= '0;
      h_im_q    <= '0;
      h_idx_q   <= '0;
      emit_q    <= '0;
    end else begin
      s2_v_q    <= s1_v_q;
      h_valid_q <= s2_v_q;
      if (s1_v_q) begin
        r_re_q <= raw_re;
        r_im_q <= raw_im;
      end
      if (start) emit_q <= '0;
      else if (s2_v_q) begin
        h_re_q  <= emit_q == 4'd0 ? r_re_q : avg(r_re_q, p_re_q);
        h_im_q  <= emit_q == 4'd0 ? r_im_q : avg(r_im_q, p_im_q);
        p_re_q  <= r_re_q;
        p_im_q  <= r_im_q;
        h_idx_q <= emit_q;
        emit_q  <= emit_q + 4'd1;
      end
    end
`else
  assign pipe_busy = s1_v_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h_valid_q <= 1'b0;
      h_re_q    <= '0;
      h_im_q    <= '0;
      h_idx_q   <= '0;
      emit_q    <= '0;
    end else begin
      h_valid_q <= s1_v_q;
      if (start) emit_q <= '0;
      else if (s1_v_q) begin
        h_re_q  <= raw_re;
        h_im_q  <= raw_im;
        h_idx_q <= emit_q;
        emit_q  <= emit_q + 4'd1;
      end
    end
`endif
endmodule

// File: tb/tb_dmrs_chest.sv
// tb_dmrs_chest: randomized self-checking bench for dmrs_chest against a wide-integer LS model.
module tb_dmrs_chest;
`ifdef DMRS_SMOOTH_EN
  localparam int LAT = 3;
  localparam bit SMOOTH = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit SMOOTH = 1'b0;
`endif
  logic clk = 0, reset = 0, chest_en = 0, in_valid = 0;
  logic [3:0] Nsc = 0;
  logic [31:0] rx_re = 0, rx_im = 0, ref_re = 0, ref_im = 0;
  logic in_ready, h_valid, busy, chest_done, nsc_err;
  logic [31:0] h_re, h_im;
  logic [3:0] h_idx;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [31:0] a, b, c, d;} pair_t;
  typedef struct packed {logic [31:0] re, im; logic [3:0] idx; logic [15:0] cyc;} est_t;
  pair_t send_q[$];
  est_t out_q[$], exp_q[$];
  int done_cyc, done_cnt, extra_rdy, timeout, busy_at_done, start_ok;

  always #5 clk = ~clk;

  dmrs_chest dut (
    .clk(clk), .reset(reset), .chest_en(chest_en), .Nsc(Nsc), .in_valid(in_valid), .in_ready(in_ready),
    .rx_re(rx_re), .rx_im(rx_im), .ref_re(ref_re), .ref_im(ref_im), .h_valid(h_valid), .h_re(h_re),
    .h_im(h_im), .h_idx(h_idx), .busy(busy), .chest_done(chest_done), .nsc_err(nsc_err)
  );

  function automatic logic [31:0] clamp(input logic signed [127:0] x);
    if (x > 128'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (x < -128'sh80000000) return 32'h80000000;
    return x[31:0];
  endfunction

  function automatic est_t ls(input pair_t p);
    logic signed [127:0] a, b, c, d;
    est_t e;
    a = $signed(p.a); b = $signed(p.b); c = $signed(p.c); d = $signed(p.d);
    e = '0;
    e.re = clamp((a * c + b * d) >>> 16);
    e.im = clamp((b * c - a * d) >>> 16);
    return e;
  endfunction

  function automatic logic [31:0] mean2(input logic [31:0] x, input logic [31:0] y);
    logic signed [127:0] s;
    s = $signed(x);
    s = s + $signed(y);
    return clamp(s >>> 1);
  endfunction

  task automatic fill(input int n, input logic [31:0] a, b, c, d);
    pair_t p;
    p = {a, b, c, d};
    send_q.delete();
    repeat (n) send_q.push_back(p);
  endtask

  task automatic fill_rand(input int n);
    pair_t p;
    send_q.delete();
    repeat (n) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(1, 0) == 1) p = {p.a >>> 12, p.b >>> 12, p.c >>> 12, p.d >>> 12};
      send_q.push_back(p);
    end
  endtask

  // Drives one estimation run and records what came out; expectations come from the model.
  task automatic run(input int nsc, input bit gaps, input int extra, input int stop_after);
    int sent = 0, t = 0, ex = extra;
    est_t e;
    est_t raw[$];
    out_q.delete(); exp_q.delete();
    done_cyc = -1; done_cnt = 0; extra_rdy = 0; timeout = 0; busy_at_done = 0;
    @(negedge clk); chest_en = 1; Nsc = 4'(nsc);
    @(negedge clk); chest_en = 0; start_ok = int'(in_ready === 1'b1 && busy === 1'b1);
    while (1) begin
      if (h_valid === 1'b1) begin e.re = h_re; e.im = h_im; e.idx = h_idx; e.cyc = 16'(t); out_q.push_back(e); end
      if (chest_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = t; busy_at_done = int'(busy); end
      end
      if (done_cyc >= 0 && t > done_cyc + 3) break;
      if (stop_after > 0 && sent == stop_after) break;
      if (t > 200) begin timeout = 1; break; end
      if (sent < nsc) begin
        in_valid = gaps ? (t % 2 == 0) : 1'b1;
        {rx_re, rx_im, ref_re, ref_im} = send_q[sent];
      end else if (ex > 0) begin
        in_valid = 1; {rx_re, rx_im, ref_re, ref_im} = {$urandom, $urandom, $urandom, $urandom};
        ex--;
        if (in_ready !== 1'b0) extra_rdy++;
      end else in_valid = 0;
      if (in_valid && in_ready === 1'b1 && sent < nsc) begin
        e = ls(send_q[sent]); e.idx = 4'(sent); e.cyc = 16'(t + LAT);
        raw.push_back(e); sent++;
      end
      @(negedge clk); t++;
    end
    in_valid = 0;
    foreach (raw[k]) begin
      e = raw[k];
      if (SMOOTH && k > 0) begin e.re = mean2(raw[k].re, raw[k-1].re); e.im = mean2(raw[k].im, raw[k-1].im); end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if ({in_ready, h_valid, h_re, h_im, h_idx, busy, chest_done, nsc_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got rdy%b hv%b re%h im%h idx%h busy%b done%b err%b want all 0",
        in_ready, h_valid, h_re, h_im, h_idx, busy, chest_done, nsc_err);
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_unity();
    fill(12, 32'h00010000, 0, 32'h00010000, 0);
    run(12, 0, 0, 0);
    n_chk++; if (start_ok !== 1) begin n_fail++; $display("FAIL unity_start: got rdy/busy %0d want 1", start_ok); end
    n_chk++; if (timeout !== 0 || out_q.size() !== 12) begin n_fail++; $display("FAIL unity_count: got %0d want 12", out_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_chk++;
      if (out_q[k] !== exp_q[k] || out_q[k].re !== 32'h00010000 || out_q[k].im !== 0 || out_q[k].idx !== 4'(k)) begin
        n_fail++; $display("FAIL unity_est%0d: got %h want %h", k, out_q[k], exp_q[k]);
      end
    end
    n_chk++;
    if (done_cnt !== 1 || done_cyc !== int'(exp_q[11].cyc) + 1 || busy_at_done !== 0) begin
      n_fail++; $display("FAIL unity_done: got cyc %0d cnt %0d busy %0d want cyc %0d cnt 1 busy 0",
        done_cyc, done_cnt, busy_at_done, int'(exp_q[11].cyc) + 1);
    end
  endtask

  task automatic test_phase();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) fill(3, 0, 32'h00010000, 32'h00010000, 0);
      else fill(3, 32'h00010000, 0, 0, 32'h00010000);
      run(3, 0, 0, 0);
      n_chk++; if (out_q.size() !== 3) begin n_fail++; $display("FAIL phase%0d_count: got %0d want 3", r, out_q.size()); end
      foreach (exp_q[k]) if (k < out_q.size()) begin
        n_chk++;
        if (out_q[k] !== exp_q[k] || out_q[k].re !== 0 || out_q[k].im !== (r == 0 ? 32'h00010000 : 32'hFFFF0000)) begin
          n_fail++; $display("FAIL phase%0d_est%0d: got %h want %h", r, k, out_q[k], exp_q[k]);
        end
      end
      n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL phase%0d_done: got %0d want 1", r, done_cnt); end
    end
  endtask

  task automatic test_illegal();
    int bad[3] = '{5, 0, 13};
    int errs, bsy, hv;
    foreach (bad[i]) begin
      errs = 0; bsy = 0; hv = 0;
      @(negedge clk); chest_en = 1; Nsc = 4'(bad[i]);
      @(negedge clk); chest_en = 0;
      repeat (4) begin
        errs += int'(nsc_err === 1'b1); bsy += int'(busy !== 1'b0); hv += int'(h_valid !== 1'b0);
        @(negedge clk);
      end
      n_chk++;
      if (errs !== 1 || bsy !== 0 || hv !== 0) begin
        n_fail++; $display("FAIL illegal_nsc%0d: got err %0d busy %0d hv %0d want 1 0 0", bad[i], errs, bsy, hv);
      end
    end
    fill_rand(6);
    run(6, 0, 0, 0);
    n_chk++; if (out_q.size() !== 6 || done_cnt !== 1) begin n_fail++; $display("FAIL illegal_then6: got %0d est %0d done want 6 1", out_q.size(), done_cnt); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_chk++; if (out_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL illegal_then6_est%0d: got %h want %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_saturation();
    fill(1, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
    run(1, 0, 0, 0);
    n_chk++;
    if (out_q.size() !== 1 || out_q[0].re !== 32'h7FFFFFFF || out_q[0].im !== 0 || out_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL sat_pos: got n%0d %h want re 7fffffff im 0", out_q.size(), out_q.size() > 0 ? out_q[0] : '0);
    end
    n_chk++; if (done_cyc !== int'(exp_q[0].cyc) + 1) begin n_fail++; $display("FAIL sat_nsc1_done: got %0d want %0d", done_cyc, int'(exp_q[0].cyc) + 1); end
    fill(1, 32'h7FFF0000, 32'h80000000, 32'h80000000, 32'h7FFF0000);
    run(1, 0, 0, 0);
    n_chk++;
    if (out_q.size() !== 1 || out_q[0].re !== 32'h80000000 || out_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL sat_neg: got n%0d %h want %h", out_q.size(), out_q.size() > 0 ? out_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_backpressure();
    fill_rand(6);
    run(6, 1, 3, 0);
    n_chk++; if (out_q.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", out_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_chk++; if (out_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_est%0d: got %h want %h", k, out_q[k], exp_q[k]); end
    end
    n_chk++; if (extra_rdy !== 0) begin n_fail++; $display("FAIL bp_extra_ready: got %0d want 0", extra_rdy); end
    n_chk++; if (done_cnt !== 1 || done_cyc !== int'(exp_q[5].cyc) + 1) begin n_fail++; $display("FAIL bp_done: got %0d want %0d", done_cyc, int'(exp_q[5].cyc) + 1); end
  endtask

  task automatic test_reset_mid();
    int hv = 0, dn = 0, bs = 0;
    fill_rand(12);
    run(12, 0, 0, 4);
    reset = 0;
    #1;
    n_chk++;
    if ({in_ready, h_valid, h_re, h_im, h_idx, busy, chest_done, nsc_err} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got rdy%b hv%b re%h im%h idx%h busy%b want all 0", in_ready, h_valid, h_re, h_im, h_idx, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (20) begin
      hv += int'(h_valid !== 1'b0); dn += int'(chest_done !== 1'b0); bs += int'(busy !== 1'b0);
      @(negedge clk);
    end
    n_chk++; if (hv !== 0 || dn !== 0 || bs !== 0) begin n_fail++; $display("FAIL midreset_quiet: got hv %0d done %0d busy %0d want 0", hv, dn, bs); end
    fill_rand(12);
    run(12, 0, 0, 0);
    n_chk++; if (out_q.size() !== 12 || done_cnt !== 1) begin n_fail++; $display("FAIL midreset_rerun: got %0d est %0d done want 12 1", out_q.size(), done_cnt); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_chk++; if (out_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL midreset_est%0d: got %h want %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int legal[4] = '{1, 3, 6, 12};
    int n;
    for (int r = 0; r < 4; r++) begin
      n = legal[$urandom_range(3, 0)];
      fill_rand(n);
      run(n, 1'($urandom_range(1, 0)), 0, 0);
      n_chk++; if (out_q.size() !== n || done_cnt !== 1) begin n_fail++; $display("FAIL b2b%0d_count: got %0d est %0d done want %0d 1", r, out_q.size(), done_cnt, n); end
      foreach (exp_q[k]) if (k < out_q.size()) begin
        n_chk++; if (out_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL b2b%0d_est%0d: got %h want %h", r, k, out_q[k], exp_q[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_phase();
    test_illegal();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmrs_chest.md
# dmrs_chest

Receive-side counterpart of the uplink DMRS generator. It takes received DMRS resource elements together with the matching locally generated reference samples, one subcarrier per beat. For each subcarrier it produces a least-squares channel estimate H = rx · conj(ref) in signed Q16.16. It sits after resource-element demapping in the NB-IoT uplink receiver and feeds equalisation.

## Interface
Parameters:
- NSC_MAX, 12, largest supported subcarrier count (counter range).
- FRAC, 16, fractional bits of every data port (Q16.16).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- chest_en  input  1  start request, sampled only in IDLE.
- Nsc  input  4  subcarrier count, latched on start; legal values 1, 3, 6, 12.
- in_valid  input  1  rx/ref sample pair present this cycle.
- in_ready  output  1  high in RUN while fewer than Nsc pairs accepted.
- rx_re, rx_im  input  32  received sample, signed Q16.16.
- ref_re, ref_im  input  32  reference sample, signed Q16.16.
- h_valid  output  1  estimate present this cycle.
- h_re, h_im  output  32  channel estimate, signed Q16.16, saturated.
- h_idx  output  4  subcarrier index of the current estimate, 0..Nsc-1.
- busy  output  1  high in RUN and DRAIN.
- chest_done  output  1  one-cycle pulse after the last estimate.
- nsc_err  output  1  one-cycle pulse when a start carries an illegal Nsc.

## Operation
States and transitions:
- IDLE
  - chest_en=1 and Nsc legal: latch Nsc, clear counters, go to RUN.
  - chest_en=1 and Nsc illegal: pulse nsc_err, stay in IDLE.
- RUN
  - A pair is accepted when in_valid && in_ready.
  - After the Nsc-th accept, go to DRAIN.
- DRAIN: wait until the pipeline is empty.
- DONE: pulse chest_done for one cycle, return to IDLE.

Data handling:
- Pairs offered while in_ready=0 are ignored.
- chest_en outside IDLE is ignored.

Arithmetic:
- Stage 1: four signed 32x32 products, 64-bit each.
- Stage 2:
  - re = rx_re·ref_re + rx_im·ref_im
  - im = rx_im·ref_re − rx_re·ref_im
  - Each sum is 65-bit. Arithmetic-shift right by FRAC, truncating toward −inf.
  - Saturate to [0x80000000, 0x7FFFFFFF].
- h_idx increments per emitted estimate and restarts at 0 on each start.

## Timing
- Reset values: in_ready=0, h_valid=0, h_re=h_im=0, h_idx=0, busy=0, chest_done=0, nsc_err=0, state IDLE.
- Start: the first cycle after an accepted chest_en has state RUN, in_ready=1 and busy=1.
- Latency: a pair accepted at edge N appears as h_valid at edge N+2; fully pipelined, one estimate per cycle.
- Gaps in in_valid propagate as gaps in h_valid; no reordering.
- in_ready drops in the cycle after the Nsc-th accept.
- chest_done is asserted the cycle after the last h_valid; busy drops in the same cycle.
- Nsc=1: a single accept, then DRAIN.
- Reset mid-operation: all outputs return to reset values immediately, the pipeline is flushed, and no chest_done is emitted.

## Configuration
- DMRS_SMOOTH_EN defined:
  - Adds one output stage, so latency is 3 cycles.
  - Estimate k>0 is the 2-tap mean (raw_k + raw_{k-1}) >>> 1, computed on 33 bits and then saturated. Estimate 0 is passed raw.
  - chest_done and the busy drop move one cycle later.
- DMRS_SMOOTH_EN undefined: raw LS estimates with 2-cycle latency as above.

## Test plan
- Unity channel: Nsc=12, every pair rx=ref=(0x00010000, 0) on consecutive cycles.
  - Required: 12 estimates h=(0x00010000, 0) with h_idx 0..11, starting 2 cycles after the first accept.
  - Required: chest_done 1 cycle after the last estimate.
- Phase rotation: Nsc=3, rx=(0, 0x00010000), ref=(0x00010000, 0).
  - Required: h=(0, 0x00010000) for all three estimates.
  - Also ref=(0, 0x00010000), rx=(0x00010000, 0) → required h=(0, 0xFFFF0000).
- Illegal Nsc: chest_en with Nsc=5.
  - Required: nsc_err pulse, busy stays 0, no h_valid.
  - Then Nsc=6 → required: 6 estimates and chest_done.
- Saturation: rx=(0x7FFF0000, 0x7FFF0000), ref=(0x7FFF0000, 0x7FFF0000).
  - Required: h_re=0x7FFFFFFF, h_im=0.
- Backpressure and gaps: Nsc=6 with in_valid toggling 1,0,1,0…, plus 3 extra pairs offered after the sixth.
  - Required: exactly 6 estimates in order, and in_ready=0 for the extras.
- Reset mid-run: assert reset after 4 of 12 accepts.
  - Required: all outputs 0, no chest_done.
  - Then a new Nsc=12 run must complete normally.
